// File: rtl/display_pkg.sv
// Shared display definitions: scan states, active-low segment patterns
// (bit 0 = segment a ... bit 6 = segment g) and active-low anode enables.
package display_pkg;

  typedef enum logic [1:0] {
    SHOW0 = 2'd0,
    GAP0  = 2'd1,
    SHOW1 = 2'd2,
    GAP1  = 2'd3
  } scan_state_t;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [1:0] AN_UNITS = 2'b10;
  localparam logic [1:0] AN_TENS  = 2'b01;
  localparam logic [1:0] AN_NONE  = 2'b11;

endpackage

// File: rtl/seg7_decode.sv
// BCD to active-low 7-segment decoder. Non-BCD codes (10..15) show a dash
// so a corrupted counter value is visible rather than silently wrong.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Map each BCD value to its segment pattern
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/two_digit_scan_driver.sv
// Two-digit common-anode 7-segment scan driver. Digits are captured into
// shadow registers on 'update' and scanned units/gap/tens/gap, with a
// one-cycle blank between digits to avoid ghosting.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module two_digit_scan_driver
  import display_pkg::*;
#(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       update,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_tick
);

  localparam int CW = $clog2(SCAN_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  scan_state_t   state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [3:0]    sh0, sh1;
  logic [3:0]    lit_digit;
  logic [6:0]    dec_seg;

  // Next-state and dwell counter: SHOW states dwell SCAN_DIV cycles, GAPs one
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      SHOW0: begin
        if (cnt == LAST) begin
          state_next = GAP0;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      GAP0: state_next = SHOW1;
      SHOW1: begin
        if (cnt == LAST) begin
          state_next = GAP1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      GAP1: state_next = SHOW0;
      default: begin
        state_next = SHOW0;
        cnt_next   = '0;
      end
    endcase
  end

  // Scan state and dwell counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= SHOW0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Shadow registers load on any update cycle, so new data shows mid-dwell
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh0 <= 4'd0;
      sh1 <= 4'd0;
    end else if (update) begin
      sh0 <= digit0;
      sh1 <= digit1;
    end
  end

  // Single shared decoder fed by whichever digit the scan is lighting
  always_comb begin
    lit_digit = (state == SHOW1) ? sh1 : sh0;
  end

  seg7_decode u_decode (
    .bcd (lit_digit),
    .seg (dec_seg)
  );

  // Moore outputs straight from state and shadow registers
  always_comb begin
    seg        = SEG_OFF;
    an         = AN_NONE;
    frame_tick = 1'b0;
    case (state)
      SHOW0: begin
        an  = AN_UNITS;
        seg = dec_seg;
      end
      SHOW1: begin
`ifdef LEADING_ZERO_BLANK_EN
        if (sh1 == 4'd0) begin
          an  = AN_NONE;
          seg = SEG_OFF;
        end else begin
          an  = AN_TENS;
          seg = dec_seg;
        end
`else
        an  = AN_TENS;
        seg = dec_seg;
`endif
      end
      GAP1: frame_tick = 1'b1;
      default: begin
        an  = AN_NONE;
        seg = SEG_OFF;
      end
    endcase
  end

endmodule

// File: tb/tb_two_digit_scan_driver.sv
// Self-checking bench for two_digit_scan_driver with a scoreboard queue.
// Optional build macro: LEADING_ZERO_BLANK_EN (bench expectations follow it).
module tb_two_digit_scan_driver;

  localparam int D     = 4;
  localparam int FRAME = 2 * D + 2;

  logic       clk;
  logic       reset;
  logic       update;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_tick;

  typedef struct packed {
    logic [1:0] an;
    logic [6:0] seg;
    logic       tick;
  } exp_t;

  exp_t expQ[$];

  int compared   = 0;
  int mismatched = 0;

  int         mPos;
  logic [3:0] mSh0;
  logic [3:0] mSh1;
  logic [6:0] segTable [16];

  two_digit_scan_driver #(.SCAN_DIV(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .update     (update),
    .digit0     (digit0),
    .digit1     (digit1),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic exp_t modelOutputs();
    exp_t e;
    e.tick = 1'b0;
    e.an   = 2'b11;
    e.seg  = 7'b1111111;
    if (mPos < D) begin
      e.an  = 2'b10;
      e.seg = segTable[mSh0];
    end else if (mPos > D && mPos < FRAME - 1) begin
      e.an  = 2'b01;
      e.seg = segTable[mSh1];
`ifdef LEADING_ZERO_BLANK_EN
      if (mSh1 == 4'd0) begin
        e.an  = 2'b11;
        e.seg = 7'b1111111;
      end
`endif
    end else if (mPos == FRAME - 1) begin
      e.tick = 1'b1;
    end
    return e;
  endfunction

  // One clock: drive inputs, advance model at the edge, compare after it
  task automatic applyStimulus(input logic upd, input logic [3:0] d0, input logic [3:0] d1);
    exp_t e;
    update = upd;
    digit0 = d0;
    digit1 = d1;
    @(posedge clk);
    if (upd) begin
      mSh0 = d0;
      mSh1 = d1;
    end
    mPos = (mPos == FRAME - 1) ? 0 : mPos + 1;
    expQ.push_back(modelOutputs());
    #1;
    if (expQ.size() == 0) begin
      checkOutput("scoreboard_empty", 8'd0, 8'd1);
    end else begin
      e = expQ.pop_front();
      checkOutput("an",         {6'd0, an},         {6'd0, e.an});
      checkOutput("seg",        {1'b0, seg},        {1'b0, e.seg});
      checkOutput("frame_tick", {7'd0, frame_tick}, {7'd0, e.tick});
    end
  endtask

  task automatic runIdle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, digit0, digit1);
  endtask

  task automatic runUntilPos(input int target);
    for (int i = 0; i < FRAME && mPos != target; i++) applyStimulus(1'b0, digit0, digit1);
    if (mPos != target) checkOutput("align_pos", 8'(mPos), 8'(target));
  endtask

  initial begin
    segTable[0]  = 7'b1000000; segTable[1]  = 7'b1111001;
    segTable[2]  = 7'b0100100; segTable[3]  = 7'b0110000;
    segTable[4]  = 7'b0011001; segTable[5]  = 7'b0010010;
    segTable[6]  = 7'b0000010; segTable[7]  = 7'b1111000;
    segTable[8]  = 7'b0000000; segTable[9]  = 7'b0010000;
    for (int i = 10; i < 16; i++) segTable[i] = 7'b0111111;

    reset  = 1'b0;
    update = 1'b0;
    digit0 = 4'd0;
    digit1 = 4'd0;
    mPos   = 0;
    mSh0   = 4'd0;
    mSh1   = 4'd0;

    $display("[TB] reset hold, including update during reset");
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        update = 1'b1;
        digit0 = 4'd8;
        digit1 = 4'd8;
      end else begin
        update = 1'b0;
      end
      @(posedge clk);
      #1;
      checkOutput("rst_an",   {6'd0, an},         8'b00000010);
      checkOutput("rst_seg",  {1'b0, seg},        8'b01000000);
      checkOutput("rst_tick", {7'd0, frame_tick}, 8'd0);
    end
    update = 1'b0;
    digit0 = 4'd0;
    digit1 = 4'd0;
    reset  = 1'b1;

    $display("[TB] scan cadence with 7/3");
    applyStimulus(1'b1, 4'd7, 4'd3);
    runIdle(2 * FRAME);

    $display("[TB] mid-dwell update to 5");
    runUntilPos(1);
    applyStimulus(1'b1, 4'd5, 4'd3);
    runIdle(FRAME + 2);

    $display("[TB] invalid BCD tens digit");
    applyStimulus(1'b1, 4'd9, 4'hC);
    runIdle(FRAME + 2);

    $display("[TB] tens digit zero");
    applyStimulus(1'b1, 4'd9, 4'd0);
    runIdle(FRAME + 2);

    $display("[TB] update held high for several cycles");
    applyStimulus(1'b1, 4'd1, 4'd2);
    applyStimulus(1'b1, 4'd4, 4'd6);
    applyStimulus(1'b1, 4'd8, 4'd5);
    runIdle(FRAME);

    $display("[TB] reset mid-frame during SHOW1");
    runUntilPos(D + 2);
    #2 reset = 1'b0;
    #1;
    checkOutput("midrst_an",   {6'd0, an},         8'b00000010);
    checkOutput("midrst_seg",  {1'b0, seg},        8'b01000000);
    checkOutput("midrst_tick", {7'd0, frame_tick}, 8'd0);
    mPos = 0;
    mSh0 = 4'd0;
    mSh1 = 4'd0;
    #1 reset = 1'b1;
    runIdle(FRAME + 2);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
